// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, write-enable and reset constants, and the
// FIFO entry type used by the writeback arbiter and its FIFO.
package wb_arbiter_pkg;
   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;

   localparam logic              WriteEnable  = 1'b1;
   localparam logic              WriteDisable = 1'b0;
   localparam logic [RegBus-1:0] ZeroWord     = '0;

   // Active-low reset levels
   localparam logic RstEnable  = 1'b0;
   localparam logic RstDisable = 1'b1;

   // One pending long-latency write: destination register plus result
   typedef struct packed {
      logic [RegAddrBus-1:0] wd;
      logic [RegBus-1:0]     wdata;
   } wb_req_t;

   // Source of the write selected in the current cycle
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_MEM  = 2'd1,
      SRC_FIFO = 2'd2
   } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: 2-entry in-order FIFO holding pending long-latency writes.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   i_push/i_data  enqueue an entry (ignored when full)
//   i_pop          dequeue the head (ignored when empty)
//   o_data         current head entry
//   o_full/o_empty occupancy flags, derived from the count
//   o_count        occupancy 0..2
module wb_fifo
   import wb_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push,
   input  wb_req_t    i_data,
   input  logic       i_pop,
   output wb_req_t    o_data,
   output logic       o_full,
   output logic       o_empty,
   output logic [1:0] o_count
);
   wb_req_t    r_mem [2];
   logic       r_wptr;
   logic       r_rptr;
   logic [1:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign w_push = i_push && (r_count != 2'd2);
   assign w_pop  = i_pop && (r_count != 2'd0);

   // Pointers are one bit and wrap naturally; full vs. empty comes from
   // r_count because equal pointers mean either condition.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop)
            r_rptr <= ~r_rptr;
         if (w_push && !w_pop)
            r_count <= r_count + 2'd1;
         else if (w_pop && !w_push)
            r_count <= r_count - 2'd1;
      end
   end

   assign o_data  = r_mem[r_rptr];
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges MEM/WB pipeline writes and long-latency unit results
// onto a single registered register-file write port.
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   mem_wreg/mem_wd/mem_wdata       pipeline write request
//   lu_valid/lu_ready/lu_wd/lu_wdata long-latency result handshake
//   we/waddr/wdata                  registered regfile write port
//   stallreq                        one-cycle pipeline bubble request
//   fifo_count                      long-latency FIFO occupancy
// Pipeline writes normally win. A FIFO head that has waited too long
// raises stallreq for one cycle, during which the head drains.
module wb_arbiter
   import wb_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_wreg,
   input  logic [RegAddrBus-1:0] mem_wd,
   input  logic [RegBus-1:0]     mem_wdata,
   input  logic                  lu_valid,
   output logic                  lu_ready,
   input  logic [RegAddrBus-1:0] lu_wd,
   input  logic [RegBus-1:0]     lu_wdata,
   output logic                  we,
   output logic [RegAddrBus-1:0] waddr,
   output logic [RegBus-1:0]     wdata,
   output logic                  stallreq,
   output logic [1:0]            fifo_count
);
   localparam logic [2:0] AGE_STALL = 3'd4;
   localparam logic [2:0] AGE_MAX   = 3'd7;

   logic                  r_we;
   logic [RegAddrBus-1:0] r_waddr;
   logic [RegBus-1:0]     r_wdata;
   logic                  r_stall;
   logic [2:0]            r_age;

   logic       w_mem_vld;
   logic       w_push;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic [1:0] w_count;
   wb_req_t    w_head;
   wb_req_t    w_lu_req;
   wb_src_e    w_src;

   assign w_mem_vld = mem_wreg && (mem_wd != '0);

   // Ready follows the registered count only, so a same-cycle pop never
   // opens the door early; it is forced low while reset is asserted.
   assign lu_ready = (rst == RstDisable) && !w_full;

   // r0 results are acknowledged but never stored
   assign w_push   = lu_valid && lu_ready && (lu_wd != '0);
   assign w_lu_req = '{wd: lu_wd, wdata: lu_wdata};

   always_comb begin
      w_src = SRC_NONE;
      if (r_stall) begin
         if (!w_empty) w_src = SRC_FIFO;
      end else if (w_mem_vld) begin
         w_src = SRC_MEM;
      end else if (!w_empty) begin
         w_src = SRC_FIFO;
      end
   end

   assign w_pop = (w_src == SRC_FIFO);

   wb_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_lu_req),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_we    <= WriteDisable;
         r_waddr <= '0;
         r_wdata <= ZeroWord;
         r_stall <= 1'b0;
         r_age   <= 3'd0;
      end else begin
         case (w_src)
            SRC_MEM: begin
               r_we    <= WriteEnable;
               r_waddr <= mem_wd;
               r_wdata <= mem_wdata;
            end
            SRC_FIFO: begin
               r_we    <= WriteEnable;
               r_waddr <= w_head.wd;
               r_wdata <= w_head.wdata;
            end
            default: begin
               r_we    <= WriteDisable;
               r_waddr <= '0;
               r_wdata <= ZeroWord;
            end
         endcase

         if (w_empty || w_pop)
            r_age <= 3'd0;
         else if (r_age != AGE_MAX)
            r_age <= r_age + 3'd1;

         // Saturation at 7 means age equals 4 at most once per waiting
         // head, so this fires once; a head that drains in that same
         // cycle needs no bubble.
         r_stall <= (r_age == AGE_STALL) && !w_pop;
      end
   end

   assign we         = r_we;
   assign waddr      = r_waddr;
   assign wdata      = r_wdata;
   assign stallreq   = r_stall;
   assign fifo_count = w_count;
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_wreg = 1'b0;
   logic [4:0]  mem_wd = '0;
   logic [31:0] mem_wdata = '0;
   logic        lu_valid = 1'b0;
   logic        lu_ready;
   logic [4:0]  lu_wd = '0;
   logic [31:0] lu_wdata = '0;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        stallreq;
   logic [1:0]  fifo_count;

   wb_arbiter dut (
      .clk(clk), .rst(rst), .mem_wreg(mem_wreg), .mem_wd(mem_wd),
      .mem_wdata(mem_wdata), .lu_valid(lu_valid), .lu_ready(lu_ready),
      .lu_wd(lu_wd), .lu_wdata(lu_wdata), .we(we), .waddr(waddr),
      .wdata(wdata), .stallreq(stallreq), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          c;
      logic [4:0]  wd;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      logic [4:0]  wd;
      logic [31:0] d;
   } ent_t;

   wr_t  sb[$];     // expected regfile writes, tagged with their cycle
   ent_t m_q[$];    // reference: results waiting in arrival order
   int   m_wait = 0; // consecutive cycles the head has been held back
   bit   m_stall = 0;
   int   n_tot = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input logic [36:0] act, input logic [36:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Pipeline must not present a real write during a bubble
   always @(posedge clk)
      if (rst && stallreq)
         assert (!(mem_wreg && mem_wd != 0))
         else $error("protocol violation: pipeline write during stallreq");

   // Monitor: every regfile write must match the scoreboard head
   always @(negedge clk) begin
      wr_t e;
      if (we === 1'b1) begin
         if (sb.size() == 0) chk("unexpected_write", {32'd0, waddr}, 37'h1f_ffff_ffff);
         else begin
            e = sb.pop_front();
            chk("write_cycle", 37'(cyc), 37'(e.c));
            chk("write", {waddr, wdata}, {e.wd, e.d});
         end
      end else if (sb.size() > 0 && sb[0].c <= cyc) begin
         chk("missing_write_we", 37'(we), 37'd1);
         void'(sb.pop_front());
      end
   end

   // One cycle: check state against the model, drive inputs, advance model
   task automatic step(input logic r, input logic mw, input logic [4:0] md,
                       input logic [31:0] mdat, input logic lv,
                       input logic [4:0] lwd, input logic [31:0] ldat);
      bit pop, was_empty, acc, stall_next;
      ent_t e;
      @(negedge clk);
      chk("fifo_count", 37'(fifo_count), 37'(m_q.size()));
      chk("stallreq", 37'(stallreq), 37'(m_stall));
      rst = r; mem_wreg = mw; mem_wd = md; mem_wdata = mdat;
      lu_valid = lv; lu_wd = lwd; lu_wdata = ldat;
      #1;
      chk("lu_ready", 37'(lu_ready), 37'(r && m_q.size() < 2));
      if (!r) begin
         m_q.delete(); m_wait = 0; m_stall = 0;
      end else begin
         acc = lv && (m_q.size() < 2);
         was_empty = (m_q.size() == 0);
         pop = 0;
         if (m_stall) pop = !was_empty;
         else if (mw && md != 0) sb.push_back('{cyc + 1, md, mdat});
         else pop = !was_empty;
         if (pop) begin
            e = m_q.pop_front();
            sb.push_back('{cyc + 1, e.wd, e.d});
         end
         stall_next = 0;
         if (pop || was_empty) m_wait = 0;
         else begin
            m_wait++;
            stall_next = (m_wait == 5); // fifth blocked cycle in a row
         end
         m_stall = stall_next;
         if (acc && lwd != 0) m_q.push_back('{lwd, ldat});
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset held: everything quiet, lu_ready low
      for (int i = 0; i < 3; i++) step(0, 1, 4, 32'hdead, 1, 3, 32'hbeef);
      chk("reset_we", 37'(we), 37'd0);
      idle(2);

      // Single pipeline write, then r0 drops
      step(1, 1, 3, 32'h1234, 0, 0, 0);
      step(1, 1, 0, 32'h5555, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0, 32'h7777);
      idle(2);
      chk("r0_push_count", 37'(fifo_count), 37'd0);

      // Three back-to-back results with no pipeline traffic
      step(1, 0, 0, 0, 1, 5, 32'h5);
      step(1, 0, 0, 0, 1, 6, 32'h6);
      step(1, 0, 0, 0, 1, 7, 32'h7);
      idle(4);

      // Same, with the pipeline holding the port so the FIFO fills
      step(1, 1, 1, 32'ha1, 1, 5, 32'h50);
      step(1, 1, 2, 32'ha2, 1, 6, 32'h60);
      step(1, 1, 3, 32'ha3, 1, 7, 32'h70);
      step(1, 0, 0, 0, 1, 7, 32'h71);
      idle(5);

      // Starved head: pipeline writes every allowed cycle
      step(1, 0, 0, 0, 1, 9, 32'h99);
      for (int i = 0; i < 10; i++) step(1, !m_stall, 20, 32'hc0 + i, 0, 0, 0);
      idle(3);

      // Reset with a full FIFO
      step(1, 1, 11, 32'hb1, 1, 12, 32'hc1);
      step(1, 1, 11, 32'hb2, 1, 13, 32'hc2);
      step(0, 1, 11, 32'hb3, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      idle(3);

      // Randomized traffic with phases of heavy and light pipeline load
      for (int ph = 0; ph < 12; ph++) begin
         int pm;
         pm = (ph % 3 == 0) ? 95 : (ph % 3 == 1) ? 50 : 15;
         for (int i = 0; i < 150; i++) begin
            logic r, mw, lv;
            logic [4:0] md, lwd;
            r   = ($urandom_range(0, 199) != 0);
            mw  = ($urandom_range(0, 99) < pm) && !m_stall;
            md  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (m_stall) md = 5'd0;
            lv  = ($urandom_range(0, 99) < 45);
            lwd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(r, mw, md, $urandom, lv, lwd, $urandom);
         end
      end
      idle(12);
      @(negedge clk);
      chk("scoreboard_drained", 37'(sb.size()), 37'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
